// File: rtl/seq_pattern_tx_if.sv
// Bus interface for seq_pattern_tx: start/data/len request side plus the
// serial x/valid and busy/done/err status outputs.
// With SEQ_PATTERN_TX_LOOP_EN defined, the loop control input is included.
interface seq_pattern_tx_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [4:0]       len;
`ifdef SEQ_PATTERN_TX_LOOP_EN
  logic             loop;
`endif
  logic             x;
  logic             valid;
  logic             busy;
  logic             done;
  logic             err;

  modport master (
    output start,
    output data,
    output len,
`ifdef SEQ_PATTERN_TX_LOOP_EN
    output loop,
`endif
    input  x,
    input  valid,
    input  busy,
    input  done,
    input  err
  );

  modport slave (
    input  start,
    input  data,
    input  len,
`ifdef SEQ_PATTERN_TX_LOOP_EN
    input  loop,
`endif
    output x,
    output valid,
    output busy,
    output done,
    output err
  );
endinterface

// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx: transmits the low len bits of data MSB-first on x, one bit
// per clock, with valid/busy/done status and an err pulse for illegal len.
// Optional feature macro: SEQ_PATTERN_TX_LOOP_EN (continuous-loop mode,
// adds the loop input to the bus interface).
module seq_pattern_tx #(
  parameter int WIDTH = 16
) (
  input  logic            clk,
  input  logic            reset,
  seq_pattern_tx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } state_t;

  localparam logic [4:0] WIDTH_L = 5'(WIDTH);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [4:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [4:0]       len_q, len_d;
  logic             x_q, x_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             len_ok;
  logic             do_loop;

  // Loop request is tied off when continuous-loop mode is not built in.
`ifdef SEQ_PATTERN_TX_LOOP_EN
  assign do_loop = bus.loop;
`else
  assign do_loop = 1'b0;
`endif

  // Next-state and next-output logic; the shift register is left-aligned so
  // the current bit always sits at the MSB and bits above len-1 are shifted
  // out at load time.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    cnt_d   = cnt_q;
    pat_d   = pat_q;
    len_d   = len_q;
    x_d     = 1'b0;
    valid_d = 1'b0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    err_d   = 1'b0;
    len_ok  = (bus.len != 5'd0) && (bus.len <= WIDTH_L);

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (len_ok) begin
            state_d = SHIFT;
            pat_d   = bus.data;
            len_d   = bus.len;
            shreg_d = bus.data << (WIDTH_L - bus.len);
            cnt_d   = bus.len - 5'd1;
            x_d     = shreg_d[WIDTH-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      SHIFT: begin
        if (cnt_q == 5'd0) begin
          if (do_loop) begin
            shreg_d = pat_q << (WIDTH_L - len_q);
            cnt_d   = len_q - 5'd1;
            x_d     = shreg_d[WIDTH-1];
            valid_d = 1'b1;
            busy_d  = 1'b1;
          end else begin
            state_d = DONE;
            shreg_d = '0;
            busy_d  = 1'b1;
            done_d  = 1'b1;
          end
        end else begin
          cnt_d   = cnt_q - 5'd1;
          shreg_d = shreg_q << 1;
          x_d     = shreg_d[WIDTH-1];
          valid_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset clears everything immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      cnt_q   <= '0;
      pat_q   <= '0;
      len_q   <= '0;
      x_q     <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      cnt_q   <= cnt_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      x_q     <= x_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.x     = x_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Scoreboard bench for seq_pattern_tx. A transaction-level model schedules
// the expected per-cycle outputs for each accepted pattern; a monitor pops
// and compares one expected observation per clock.
module tb_seq_pattern_tx;

  localparam int WIDTH = 16;

  typedef struct packed {
    logic x;
    logic valid;
    logic busy;
    logic done;
    logic err;
  } obs_t;

  logic clk;
  logic reset;

  seq_pattern_tx_if #(.WIDTH(WIDTH)) bus ();

  seq_pattern_tx #(.WIDTH(WIDTH)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  obs_t       exp_q[$];
  obs_t       pend[$];
  logic       cur_busy;
  logic [15:0] m_data;
  logic [4:0]  m_len;
  int         checks;
  int         passes;
  int         cyc;

  // Expected outputs of one pattern: len bit cycles then one done cycle.
  task automatic push_pattern(input logic [15:0] d, input logic [4:0] l);
    obs_t o;
    for (int unsigned k = 0; k < int'(l); k++) begin
      o = '0;
      o.x     = d[int'(l) - 1 - int'(k)];
      o.valid = 1'b1;
      o.busy  = 1'b1;
      pend.push_back(o);
    end
    o = '0;
    o.busy = 1'b1;
    o.done = 1'b1;
    pend.push_back(o);
  endtask

  // Predict the output for the cycle following the upcoming rising edge.
  task automatic model_edge();
    obs_t o;
    o = '0;
    if (reset) begin
      pend.delete();
    end else if (pend.size() != 0) begin
`ifdef SEQ_PATTERN_TX_LOOP_EN
      if (pend[0].done && bus.loop) begin
        pend.delete();
        push_pattern(m_data, m_len);
      end
`endif
      o = pend.pop_front();
    end else if (bus.start && !cur_busy) begin
      if (bus.len >= 5'd1 && int'(bus.len) <= WIDTH) begin
        m_data = bus.data;
        m_len  = bus.len;
        push_pattern(m_data, m_len);
        o = pend.pop_front();
      end else begin
        o.err = 1'b1;
      end
    end
    cur_busy = o.busy;
    exp_q.push_back(o);
  endtask

  task automatic cycle();
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic s, input logic [15:0] d, input logic [4:0] l);
    bus.start = s;
    bus.data  = d;
    bus.len   = l;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int unsigned k = 0; k < n; k++)
      drive(1'b0, 16'($urandom), 5'($urandom));
  endtask

  // Monitor: one comparison per clock, sampled after the active edge.
  initial begin
    obs_t e, a;
    cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      a = {bus.x, bus.valid, bus.busy, bus.done, bus.err};
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_empty cycle %0d: got %b, required an expected entry", cyc, a);
      end else begin
        e = exp_q.pop_front();
        if (a === e) passes++;
        else
          $display("FAIL cycle %0d: got x/valid/busy/done/err=%b, required %b",
                   cyc, a, e);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    obs_t a;
    checks   = 0;
    passes   = 0;
    cur_busy = 1'b0;
    m_data   = '0;
    m_len    = '0;
    reset    = 1'b1;
    bus.start = 1'b0;
    bus.data  = '0;
    bus.len   = '0;
`ifdef SEQ_PATTERN_TX_LOOP_EN
    bus.loop  = 1'b0;
`endif

    // Reset state, then first start right after release.
    cycle();
    cycle();
    reset = 1'b0;
    drive(1'b1, 16'h000A, 5'd4);
    idle(7);

    // len=7 pattern with an ignored start pulse mid-transfer.
    drive(1'b1, 16'h006A, 5'd7);
    idle(2);
    drive(1'b1, 16'($urandom), 5'd3);
    idle(8);

    // Illegal lengths.
    drive(1'b1, 16'hFFFF, 5'd0);
    idle(1);
    drive(1'b1, 16'hFFFF, 5'd17);
    idle(1);
    drive(1'b1, 16'hFFFF, 5'd31);
    idle(2);

    // Full-width and single-bit patterns with noise in the unused bits.
    drive(1'b1, 16'hB5C3, 5'd16);
    idle(18);
    drive(1'b1, 16'hFFFE, 5'd1);
    idle(3);

    // Asynchronous reset during the third bit of a len=8 transfer.
    drive(1'b1, 16'hFF5A, 5'd8);
    idle(2);
    #1 reset = 1'b1;
    #1;
    a = {bus.x, bus.valid, bus.busy, bus.done, bus.err};
    checks++;
    if (a === '0) passes++;
    else $display("FAIL async_reset: got x/valid/busy/done/err=%b, required 00000", a);
    pend.delete();
    cur_busy = 1'b0;
    cycle();
    cycle();
    reset = 1'b0;
    drive(1'b1, 16'h00C5, 5'd8);
    idle(11);

    // start held high: back-to-back patterns with a done and an idle gap.
    bus.start = 1'b1;
    bus.data  = 16'h000A;
    bus.len   = 5'd4;
    for (int unsigned k = 0; k < 16; k++) cycle();
    idle(3);

`ifdef SEQ_PATTERN_TX_LOOP_EN
    // Three contiguous passes of 1010, then a single done.
    bus.loop = 1'b1;
    drive(1'b1, 16'h000A, 5'd4);
    for (int unsigned k = 0; k < 11; k++) drive(1'b0, 16'($urandom), 5'($urandom));
    bus.loop = 1'b0;
    idle(4);
`endif

    // Randomized traffic with occasional resets.
    for (int unsigned k = 0; k < 400; k++) begin
      reset = ($urandom_range(0, 59) == 0);
`ifdef SEQ_PATTERN_TX_LOOP_EN
      bus.loop = ($urandom_range(0, 3) == 0);
`endif
      drive($urandom_range(0, 9) < 4, 16'($urandom), 5'($urandom_range(0, 20)));
    end
    reset = 1'b0;
`ifdef SEQ_PATTERN_TX_LOOP_EN
    bus.loop = 1'b0;
`endif
    idle(24);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
